// File: rtl/parity_uart_rx_pkg.sv
// Shared constants for the parity serial receiver: FSM state codes, default sizing, line levels.
// Latency and backpressure are not applicable: this is a declarations-only package.
package parity_uart_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_W       = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/parity_uart_rx_bit_sync.sv
// Two-flop synchronizer for the asynchronous serial pin; reset forces the idle line level.
// Latency: 2 clocks. No backpressure: the output follows the input every cycle.
module parity_uart_rx_bit_sync
  import parity_uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= IDLE_LVL;
      q    <= IDLE_LVL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parity_uart_rx.sv
// Oversampling serial frame receiver (start, LSB-first data, XOR parity, stop) with error flags.
// Latency: VALID at t0+H+(DATA_W+2)*CLKS_PER_BIT; no backpressure, VALID is a single-cycle pulse.
module parity_uart_rx
  import parity_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              RXD,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  output logic              PAR_ERR,
  output logic              FRM_ERR,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int H     = CLKS_PER_BIT >> 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic              rxs;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              xor_acc;
  logic              par_bad;
  logic              half_hit;
  logic              bit_hit;

  parity_uart_rx_bit_sync u_sync (
    .clk  (CLK),
    .rstn (RSTN),
    .d    (RXD),
    .q    (rxs)
  );

  assign half_hit = (cnt == HALF_M1);
  assign bit_hit  = (cnt == BIT_M1);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      xor_acc <= 1'b0;
      par_bad <= 1'b0;
      DATA    <= '0;
      VALID   <= 1'b0;
      PAR_ERR <= 1'b0;
      FRM_ERR <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      // BUSY trails the state register by one cycle, so it drops the cycle after IDLE is entered.
      BUSY  <= (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (rxs == START_LVL) begin
            state   <= ST_START;
            cnt     <= '0;
            bit_idx <= '0;
            xor_acc <= 1'b0;
          end
        end

        ST_START: begin
          if (half_hit) begin
            cnt   <= '0;
            state <= (rxs == START_LVL) ? ST_DATA : ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_hit) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[DATA_W-1:1]};
            xor_acc <= xor_acc ^ rxs;
            if (bit_idx == LAST_IDX) begin
              state <= ST_PARITY;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_PARITY: begin
          if (bit_hit) begin
            cnt     <= '0;
            par_bad <= ((xor_acc ^ rxs) != PARITY_ODD);
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (bit_hit) begin
            cnt     <= '0;
            DATA    <= shreg;
            VALID   <= 1'b1;
            PAR_ERR <= par_bad;
            FRM_ERR <= (rxs != STOP_LVL);
            // Leaving mid stop bit lets a start edge right after the stop bit be caught.
            state   <= (rxs == STOP_LVL) ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_WAIT_HIGH: begin
          if (rxs == IDLE_LVL) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_uart_rx.sv
// Directed bench for parity_uart_rx: an even-parity instance and an odd-parity instance on one clock.
module tb_parity_uart_rx;

  logic       clk;
  logic       rstn;
  logic       rxd_a, rxd_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       perr_a, perr_b;
  logic       ferr_a, ferr_b;
  logic       busy_a, busy_b;

  int n_tests;
  int n_fail;
  int cyc;
  int vcnt_a;
  int vcnt_b;
  int last_stamp;
  int v0, s1, s2;

  parity_uart_rx #(.CLKS_PER_BIT(16), .DATA_W(8), .PARITY_ODD(1'b0)) u_dut_even (
    .CLK(clk), .RSTN(rstn), .RXD(rxd_a), .DATA(data_a), .VALID(valid_a),
    .PAR_ERR(perr_a), .FRM_ERR(ferr_a), .BUSY(busy_a)
  );

  parity_uart_rx #(.CLKS_PER_BIT(16), .DATA_W(8), .PARITY_ODD(1'b1)) u_dut_odd (
    .CLK(clk), .RSTN(rstn), .RXD(rxd_b), .DATA(data_b), .VALID(valid_b),
    .PAR_ERR(perr_b), .FRM_ERR(ferr_b), .BUSY(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc    = 0;
    vcnt_a = 0;
    vcnt_b = 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid_a === 1'b1) vcnt_a <= vcnt_a + 1;
    if (valid_b === 1'b1) vcnt_b <= vcnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) rxd_b = v;
    else       rxd_a = v;
  endtask

  task automatic drive_bit(input bit which, input logic v);
    set_line(which, v);
    repeat (16) @(posedge clk);
    #1;
  endtask

  // Drives start, data and parity, then leaves the stop level on the line 160 edges after the start.
  task automatic send_head(input bit which, input logic [7:0] d, input logic par, input logic stp);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    drive_bit(which, par);
    set_line(which, stp);
  endtask

  // Called at start+160; VALID is expected after edge start+171 (t0+168), BUSY update one edge later.
  task automatic expect_frame(input string tag, input bit which, input logic [7:0] d,
                              input logic pe, input logic fe);
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_valid_early"}, which ? valid_b : valid_a, 1'b0);
    @(posedge clk);
    #1;
    last_stamp = cyc;
    chk({tag, "_valid"}, which ? valid_b : valid_a, 1'b1);
    chk({tag, "_data"},  which ? data_b  : data_a,  d);
    chk({tag, "_perr"},  which ? perr_b  : perr_a,  pe);
    chk({tag, "_ferr"},  which ? ferr_b  : ferr_a,  fe);
    chk({tag, "_busy_at_valid"}, which ? busy_b : busy_a, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, "_valid_pulse_end"}, which ? valid_b : valid_a, 1'b0);
    chk({tag, "_busy_after"}, which ? busy_b : busy_a, fe);
    chk({tag, "_data_held"}, which ? data_b : data_a, d);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rxd_a   = 1'b1;
    rxd_b   = 1'b1;
    rstn    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_a",  data_a,  8'h00);
    chk("rst_valid_a", valid_a, 1'b0);
    chk("rst_perr_a",  perr_a,  1'b0);
    chk("rst_ferr_a",  ferr_a,  1'b0);
    chk("rst_busy_a",  busy_a,  1'b0);
    chk("rst_data_b",  data_b,  8'h00);
    chk("rst_busy_b",  busy_b,  1'b0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 1: good even-parity frame
    send_head(1'b0, 8'hA5, 1'b0, 1'b1);
    expect_frame("t1", 1'b0, 8'hA5, 1'b0, 1'b0);

    // 2: wrong parity bit
    send_head(1'b0, 8'h07, 1'b0, 1'b1);
    expect_frame("t2", 1'b0, 8'h07, 1'b1, 1'b0);

    // 3: stop bit low, line held low 40 more cycles
    v0 = vcnt_a;
    send_head(1'b0, 8'h3C, 1'b0, 1'b0);
    expect_frame("t3", 1'b0, 8'h3C, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_busy_held_low", busy_a, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_busy_before_high", busy_a, 1'b1);
    set_line(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_busy_wait_exit", busy_a, 1'b1);
    @(posedge clk);
    #1;
    chk("t3_busy_idle", busy_a, 1'b0);
    chk("t3_one_valid", vcnt_a, v0 + 1);
    repeat (5) @(posedge clk);
    #1;

    // 4: 4-cycle glitch; t0 is 3 edges after the line drops
    v0 = vcnt_a;
    set_line(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    set_line(1'b0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    chk("t4_busy_t0p8", busy_a, 1'b1);
    @(posedge clk);
    #1;
    chk("t4_busy_t0p9", busy_a, 1'b0);
    chk("t4_no_valid", vcnt_a, v0);
    chk("t4_data_kept", data_a, 8'h3C);
    chk("t4_perr_kept", perr_a, 1'b0);
    chk("t4_ferr_kept", ferr_a, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    // 5: reset after data bit 4 of 0x11, then a clean frame
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] pat;
      pat = 8'h11;
      drive_bit(1'b0, pat[i]);
    end
    rstn = 1'b0;
    set_line(1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("t5_rst_data",  data_a,  8'h00);
    chk("t5_rst_valid", valid_a, 1'b0);
    chk("t5_rst_perr",  perr_a,  1'b0);
    chk("t5_rst_ferr",  ferr_a,  1'b0);
    chk("t5_rst_busy",  busy_a,  1'b0);
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_head(1'b0, 8'h5A, 1'b0, 1'b1);
    expect_frame("t5", 1'b0, 8'h5A, 1'b0, 1'b0);

    // 6: odd parity, back-to-back frames
    v0 = vcnt_b;
    send_head(1'b1, 8'h00, 1'b1, 1'b1);
    expect_frame("t6a", 1'b1, 8'h00, 1'b0, 1'b0);
    s1 = last_stamp;
    send_head(1'b1, 8'hFF, 1'b1, 1'b1);
    expect_frame("t6b", 1'b1, 8'hFF, 1'b0, 1'b0);
    s2 = last_stamp;
    chk("t6_spacing", s2 - s1, 176);
    chk("t6_two_valids", vcnt_b, v0 + 2);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_busy_idle", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_uart_rx.md
Name: parity_uart_rx

Overview:
Serial frame receiver with a parity check. It is the receive end of the team's XOR-based parity serial link. The line carries frames of 1 start bit (0), DATA_W data bits (LSB first), 1 parity bit and 1 stop bit (1); the line idles high. The block oversamples the line, recovers the data byte, recomputes the XOR parity and flags parity and framing errors. It sits between the board serial pin and the control logic.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥4; half-bit H = CLKS_PER_BIT>>1
DATA_W, 8, data bits per frame
PARITY_ODD, 0, 0 = even parity (XOR of data and parity bit is 0); 1 = odd parity (XOR is 1)

Ports:
CLK  in  1  system clock, rising edge
RSTN  in  1  synchronous active-low reset
RXD  in  1  asynchronous serial line, idle high
DATA  out  DATA_W  last received data word
VALID  out  1  one-cycle pulse when a frame completes
PAR_ERR  out  1  parity mismatch on last frame; valid with VALID, held until next VALID
FRM_ERR  out  1  stop bit sampled 0 on last frame; valid with VALID, held until next VALID
BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, CLK. Reset RSTN is synchronous and active-low.
- Reset (RSTN=0 at a CLK edge): state=IDLE; DATA=0, VALID=0, PAR_ERR=0, FRM_ERR=0, BUSY=0; synchronizer flops=1; counters and shift register cleared. Reset mid-frame discards the partial frame.
- RXD passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- Timing reference t0 = the edge at which IDLE samples rxs=0. IDLE moves to START at t0; the bit counter is cleared.
- START: sample at t0+H.
  - rxs=1 means a glitch: return to IDLE with no VALID and no flags.
  - rxs=0: enter DATA.
- DATA: bit i (i=0..DATA_W-1) is sampled at t0+H+(i+1)*CLKS_PER_BIT and shifted in LSB first. A running XOR is accumulated. After bit DATA_W-1, enter PARITY.
- PARITY: sample at t0+H+(DATA_W+1)*CLKS_PER_BIT.
  - par_bad = (xor_acc ^ sample) != PARITY_ODD.
- STOP: sample at t0+H+(DATA_W+2)*CLKS_PER_BIT. At that edge, registered:
  - DATA = shift register
  - VALID = 1 for exactly one cycle
  - PAR_ERR = par_bad
  - FRM_ERR = ~sample
- After STOP:
  - sample=1: go to IDLE at once (mid stop bit), so back-to-back frames are accepted.
  - sample=0: go to WAIT_HIGH, which stays until rxs=1, then goes to IDLE. A held-low line never starts a new frame.
- Defaults: CLKS_PER_BIT=16, DATA_W=8 gives the stop sample and VALID at t0+168. The VALID cycle is t0+168 to t0+169.
- DATA, PAR_ERR and FRM_ERR change only at a VALID edge or at reset.
- The counter width is $clog2(CLKS_PER_BIT). The sample counter wraps to 0 at each sample point; the bit index saturates at DATA_W-1.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE..WAIT_HIGH)
  - default CLKS_PER_BIT and DATA_W
  - frame-bit constants: START_LVL=0, STOP_LVL=1, IDLE_LVL=1
- One natural sub-module: bit_sync, the 2-flop synchronizer with reset value 1. The parity XOR stays inline.

Test Plan:
1. Even parity, frame 0xA5, parity 0, stop 1 -> VALID pulse at t0+168; DATA=0xA5, PAR_ERR=0, FRM_ERR=0; BUSY falls at t0+169.
2. Frame 0x07 sent with parity bit 0 (wrong, three ones) -> VALID at t0+168; DATA=0x07, PAR_ERR=1, FRM_ERR=0.
3. Frame 0x3C, parity 0, stop bit 0, line held low 40 more cycles then high -> VALID with FRM_ERR=1; no new START until the line goes high and then low again.
4. RXD low for 4 cycles then high (glitch) -> no VALID; BUSY returns 0 at t0+9; DATA, PAR_ERR and FRM_ERR unchanged.
5. RSTN pulsed low for 1 cycle after data bit 4 of 0x11 -> all outputs 0 next cycle; following frame 0x5A decodes with DATA=0x5A and no errors.
6. PARITY_ODD=1, back-to-back frames 0x00 (parity 1) then 0xFF (parity 1), second start immediately after the stop bit -> two VALID pulses 176 cycles apart, DATA 0x00 then 0xFF, no errors.
